// File: rtl/cpu_pkg.sv
// Shared definitions for the parameterised multi-cycle core.
// Opcodes, ALU operation codes, FSM state type and status bit positions.
package cpu_pkg;

  localparam logic [3:0] OP_MVR = 4'h0;
  localparam logic [3:0] OP_LDB = 4'h1;
  localparam logic [3:0] OP_STB = 4'h2;
  localparam logic [3:0] OP_RDS = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_ORA = 4'hA;
  localparam logic [3:0] OP_ADD = 4'hB;
  localparam logic [3:0] OP_SUB = 4'hC;
  localparam logic [3:0] OP_XOR = 4'hD;
  localparam logic [3:0] OP_INC = 4'hE;

  // ALU op is the low three bits of an ALU opcode (8..14).
  localparam logic [2:0] ALU_NOT = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_ORA = 3'd2;
  localparam logic [2:0] ALU_ADD = 3'd3;
  localparam logic [2:0] ALU_SUB = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_INC = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam int ST_CARRY = 0;
  localparam int ST_ZERO  = 1;
  localparam int ST_ILL   = 2;

  function automatic logic is_alu(input logic [3:0] op);
    return op[3] && (op != 4'hF);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op[3:2] == 2'b01) || (op == 4'hF);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: op_i selects function, y_o result, c_o carry, z_o zero.
// Ports: op_i[2:0], a_i/b_i operands, y_o result, c_o carry/borrow, z_o.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              c_o,
  output logic              z_o
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;

  assign sum = {1'b0, a_i} + {1'b0, b_i};
  // Top bit of the extended difference is the unsigned borrow.
  assign dif = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    y_o = '0;
    c_o = 1'b0;
    case (op_i)
      ALU_NOT: y_o = ~a_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_ORA: y_o = a_i | b_i;
      ALU_ADD: begin
        y_o = sum[DATA_W-1:0];
        c_o = sum[DATA_W];
      end
      ALU_SUB: begin
        y_o = dif[DATA_W-1:0];
        c_o = dif[DATA_W];
      end
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_INC: begin
        y_o = a_i + ONE;
        c_o = &a_i;
      end
      default: y_o = '0;
    endcase
  end

  assign z_o = (y_o == '0);

endmodule

// File: rtl/param_cpu_core.sv
// Multi-cycle core: IDLE -> READ -> EXEC -> WB, register file and FSM.
// Ports: instr_valid/ready handshake, opcode/rd/rs1/rs2/imm, data_out(+valid), status.
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int REG_COUNT = 16,
  localparam int RA_W      = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [RA_W-1:0]   rd,
  input  logic [RA_W-1:0]   rs1,
  input  logic [RA_W-1:0]   rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic [2:0]        status
);

  state_t              state_q, state_d;
  logic [3:0]          op_q;
  logic [RA_W-1:0]     rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0]   imm_q, a_q, b_q;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                c_q, z_q;
  logic [DATA_W-1:0]   rf_q [REG_COUNT];
  logic [DATA_W-1:0]   dout_q;
  logic                dov_q;
  logic [2:0]          st_q;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_c, alu_z;
  logic                wr_en;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i (op_q[2:0]),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y),
    .c_o  (alu_c),
    .z_o  (alu_z)
  );

  assign instr_ready    = (state_q == S_IDLE);
  assign data_out       = dout_q;
  assign data_out_valid = dov_q;
  assign status         = st_q;

  assign wr_en = (op_q == OP_MVR) || (op_q == OP_LDB) || is_alu(op_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_d = alu_y;
    if (op_q == OP_MVR)      res_d = a_q;
    else if (op_q == OP_LDB) res_d = imm_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      dout_q  <= '0;
      dov_q   <= 1'b0;
      st_q    <= '0;
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      dov_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= opcode;
            rd_q  <= rd;
            rs1_q <= rs1;
            rs2_q <= rs2;
            imm_q <= imm;
          end
        end
        // Operands are latched before any write, so rd==rs aliasing is safe.
        S_READ: begin
          a_q <= rf_q[rs1_q];
          b_q <= rf_q[rs2_q];
        end
        S_EXEC: begin
          res_q <= res_d;
          c_q   <= alu_c;
          z_q   <= alu_z;
        end
        S_WB: begin
          if (wr_en) rf_q[rd_q] <= res_q;
          if (is_alu(op_q)) begin
            st_q[ST_CARRY] <= c_q;
            st_q[ST_ZERO]  <= z_q;
          end
          if (op_q == OP_STB) begin
            dout_q <= a_q;
            dov_q  <= 1'b1;
          end
          if (op_q == OP_RDS) begin
            dout_q <= {{(DATA_W-3){1'b0}}, st_q};
            dov_q  <= 1'b1;
          end
          if (is_illegal(op_q)) st_q[ST_ILL] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu_core.sv
// Scoreboard bench for param_cpu_core (8/16 and 16/32 instances).
// Expected data_out words are queued at issue and checked by monitors.
module tb_param_cpu_core;

  localparam logic [3:0] MVR = 4'h0, LDB = 4'h1, STB = 4'h2, RDS = 4'h3;
  localparam logic [3:0] NOT = 4'h8, AND = 4'h9, ORA = 4'hA, ADD = 4'hB;
  localparam logic [3:0] SUB = 4'hC, XOR = 4'hD, INC = 4'hE;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic       iv0 = 1'b0, rdy0, dov0;
  logic [3:0] op0 = '0, rd0 = '0, ra0 = '0, rb0 = '0;
  logic [7:0] im0 = '0, dout0;
  logic [2:0] st0;

  logic        iv1 = 1'b0, rdy1, dov1;
  logic [3:0]  op1 = '0;
  logic [4:0]  rd1 = '0, ra1 = '0, rb1 = '0;
  logic [15:0] im1 = '0, dout1;
  logic [2:0]  st1;

  param_cpu_core u0 (
    .clk(clk), .rst(rst), .instr_valid(iv0), .instr_ready(rdy0),
    .opcode(op0), .rd(rd0), .rs1(ra0), .rs2(rb0), .imm(im0),
    .data_out(dout0), .data_out_valid(dov0), .status(st0)
  );

  param_cpu_core #(.DATA_W(16), .REG_COUNT(32)) u1 (
    .clk(clk), .rst(rst), .instr_valid(iv1), .instr_ready(rdy1),
    .opcode(op1), .rd(rd1), .rs1(ra1), .rs2(rb1), .imm(im1),
    .data_out(dout1), .data_out_valid(dov1), .status(st1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  logic pv0 = 1'b0, pv1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (pv0) chk("pulse0", {31'd0, dov0}, 32'd0);
      if (dov0) begin
        if (q0.size() == 0) chk("unexpected0", {31'd0, dov0}, 32'd0);
        else begin
          e = q0.pop_front();
          chk("dout0", {24'd0, dout0}, {16'd0, e.d});
          chk("lat0", cyc, e.c);
        end
      end
    end
    pv0 = dov0 && !rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (pv1) chk("pulse1", {31'd0, dov1}, 32'd0);
      if (dov1) begin
        if (q1.size() == 0) chk("unexpected1", {31'd0, dov1}, 32'd0);
        else begin
          e = q1.pop_front();
          chk("dout1", {16'd0, dout1}, {16'd0, e.d});
          chk("lat1", cyc, e.c);
        end
      end
    end
    pv1 = dov1 && !rst;
  end

  task automatic wait_rdy(input int u);
    int n = 0;
    while (!(u == 0 ? rdy0 : rdy1) && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(u == 0 ? rdy0 : rdy1)) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input int u, input logic [3:0] op,
                       input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [15:0] im,
                       input bit push, input logic [15:0] ex);
    int c0;
    wait_rdy(u);
    c0 = cyc;
    if (u == 0) begin
      op0 = op; rd0 = d[3:0]; ra0 = s1[3:0]; rb0 = s2[3:0];
      im0 = im[7:0]; iv0 = 1'b1;
    end else begin
      op1 = op; rd1 = d; ra1 = s1; rb1 = s2; im1 = im; iv1 = 1'b1;
    end
    if (push) begin
      if (u == 0) q0.push_back('{d: ex, c: c0 + 4});
      else q1.push_back('{d: ex, c: c0 + 4});
    end
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
  endtask

  task automatic stb(input int u, input logic [4:0] r, input logic [15:0] ex);
    issue(u, STB, 5'd0, r, 5'd0, 16'h0, 1'b1, ex);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", {29'd0, st0}, 32'd0);
    chk("rst_dout", {24'd0, dout0}, 32'd0);
    chk("rst_dov", {31'd0, dov0}, 32'd0);
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(0, LDB, 5'd3, 5'd0, 5'd0, 16'h5A, 1'b0, 16'h0);
    stb(0, 5'd3, 16'h5A);

    issue(0, LDB, 5'd1, 5'd0, 5'd0, 16'hFF, 1'b0, 16'h0);
    issue(0, LDB, 5'd2, 5'd0, 5'd0, 16'h01, 1'b0, 16'h0);
    issue(0, ADD, 5'd4, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0);
    wait_rdy(0);
    chk("add_status", {29'd0, st0}, 32'd3);
    stb(0, 5'd4, 16'h00);
    issue(0, RDS, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 16'h03);

    issue(0, LDB, 5'd1, 5'd0, 5'd0, 16'h10, 1'b0, 16'h0);
    issue(0, LDB, 5'd2, 5'd0, 5'd0, 16'h20, 1'b0, 16'h0);
    issue(0, SUB, 5'd5, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0);
    wait_rdy(0);
    chk("sub_status", {29'd0, st0}, 32'd1);
    stb(0, 5'd5, 16'hF0);
    issue(0, INC, 5'd6, 5'd1, 5'd0, 16'h0, 1'b0, 16'h0);
    wait_rdy(0);
    chk("inc_status", {29'd0, st0}, 32'd0);
    stb(0, 5'd6, 16'h11);

    issue(0, MVR, 5'd6, 5'd5, 5'd0, 16'h0, 1'b0, 16'h0);
    stb(0, 5'd6, 16'hF0);
    issue(0, ADD, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0, 16'h0);
    stb(0, 5'd1, 16'h20);
    issue(0, XOR, 5'd7, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0);
    wait_rdy(0);
    chk("xor_status", {29'd0, st0}, 32'd2);
    issue(0, NOT, 5'd8, 5'd7, 5'd0, 16'h0, 1'b0, 16'h0);
    issue(0, ORA, 5'd9, 5'd3, 5'd1, 16'h0, 1'b0, 16'h0);
    issue(0, AND, 5'd10, 5'd8, 5'd3, 16'h0, 1'b0, 16'h0);
    stb(0, 5'd8, 16'hFF);
    stb(0, 5'd9, 16'h7A);
    stb(0, 5'd10, 16'h5A);
    wait_rdy(0);
    chk("and_status", {29'd0, st0}, 32'd0);

    issue(0, 4'h5, 5'd3, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0);
    wait_rdy(0);
    chk("ill_status", {29'd0, st0}, 32'd4);
    issue(0, 4'hF, 5'd3, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0);
    stb(0, 5'd3, 16'h5A);
    issue(0, ADD, 5'd11, 5'd1, 5'd2, 16'h0, 1'b0, 16'h0);
    stb(0, 5'd11, 16'h40);
    issue(0, RDS, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 16'h04);

    issue(0, LDB, 5'd12, 5'd0, 5'd0, 16'h11, 1'b0, 16'h0);
    chk("busy_read", {31'd0, rdy0}, 32'd0);
    iv0 = 1'b1; op0 = STB; ra0 = 4'd12;
    @(posedge clk);
    #1;
    chk("busy_exec", {31'd0, rdy0}, 32'd0);
    iv0 = 1'b0;
    @(posedge clk);
    #1;
    chk("busy_wb", {31'd0, rdy0}, 32'd0);
    iv0 = 1'b1; op0 = LDB; rd0 = 4'd12; im0 = 8'h99;
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    stb(0, 5'd12, 16'h11);

    issue(0, LDB, 5'd3, 5'd0, 5'd0, 16'h77, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_status", {29'd0, st0}, 32'd0);
    chk("abort_dout", {24'd0, dout0}, 32'd0);
    chk("abort_ready", {31'd0, rdy0}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stb(0, 5'd3, 16'h00);
    issue(0, RDS, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 16'h00);

    issue(1, LDB, 5'd31, 5'd0, 5'd0, 16'hFFFF, 1'b0, 16'h0);
    issue(1, INC, 5'd31, 5'd31, 5'd0, 16'h0, 1'b0, 16'h0);
    wait_rdy(1);
    chk("w_inc_status", {29'd0, st1}, 32'd3);
    issue(1, LDB, 5'd0, 5'd0, 5'd0, 16'h1234, 1'b0, 16'h0);
    stb(1, 5'd31, 16'h0000);
    stb(1, 5'd0, 16'h1234);
    issue(1, LDB, 5'd31, 5'd0, 5'd0, 16'hABCD, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("w_abort_status", {29'd0, st1}, 32'd0);
    chk("w_abort_dout", {16'd0, dout1}, 32'd0);
    chk("w_abort_dov", {31'd0, dov1}, 32'd0);
    chk("w_abort_ready", {31'd0, rdy1}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stb(1, 5'd31, 16'h0000);
    issue(1, RDS, 5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 16'h0000);

    wait_rdy(0);
    wait_rdy(1);
    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
